// File: rtl/debounce_scheduler_if.sv
// Button/debounce bundle shared by debounce_scheduler and its clients.
// master drives the raw buttons; slave (the scheduler) drives the debounced results.
interface debounce_scheduler_if #(
    parameter int N = 4
) ();
    localparam int GW = $clog2(N);

    logic [N-1:0]  btn;
    logic [N-1:0]  d;
    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    logic          busy;
    logic [GW-1:0] grant;

    modport master (output btn, input d, rise, fall, busy, grant);
    modport slave  (input btn, output d, rise, fall, busy, grant);
endinterface

// File: rtl/debounce_scheduler.sv
// One stable-window timer shared round-robin among N buttons; debounced levels plus edge pulses.
// Define DEBOUNCE_SCHED_SYNC_EN to insert a 2-flop synchronizer on every btn bit.
module debounce_scheduler #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    debounce_scheduler_if.slave  bus
);
    localparam int TW = $clog2(STABLE_CYCLES);
    localparam int GW = $clog2(N);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [N-1:0]  s_s;
    logic [N-1:0]  req_s;
    logic          pick_found_s;
    logic [GW-1:0] pick_idx_s;

    logic [0:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q,  last_d;
    logic [N-1:0]  d_q,     d_d;
    logic [N-1:0]  rise_q,  rise_d;
    logic [N-1:0]  fall_q,  fall_d;

`ifdef DEBOUNCE_SCHED_SYNC_EN
    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync2_q;

    // Two-stage synchronizer for the asynchronous button levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    assign s_s = sync2_q;
`else
    assign s_s = bus.btn;
`endif

    assign req_s = s_s ^ d_q;

    // Circular priority scan starting just after the previous owner
    always_comb begin
        int idx;
        idx          = 0;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!pick_found_s && req_s[idx]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = GW'(idx);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic; pulses default low so they last exactly one cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        grant_d = grant_q;
        last_d  = last_q;
        d_d     = d_q;
        rise_d  = '0;
        fall_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_idx_s;
                    timer_d = '0;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (!req_s[grant_q]) begin
                    // Bounced back: release the timer but still advance priority
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
                    d_d[grant_q]    = s_s[grant_q];
                    rise_d[grant_q] = s_s[grant_q];
                    fall_d[grant_q] = ~s_s[grant_q];
                    last_d          = grant_q;
                    state_d         = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            d_q     <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            d_q     <= d_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.d     = d_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.busy  = (state_q == COUNT);
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler: vector table, directed corner sequences,
// and randomized buttons against a cycle-level behavioural model.
module tb_debounce_scheduler;
    localparam int N  = 4;
    localparam int SC = 8;
    localparam int GW = $clog2(N);
`ifdef DEBOUNCE_SCHED_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounce_scheduler_if #(.N(N)) bus ();

    debounce_scheduler #(.N(N), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: who owns the timer, how many stable cycles it has seen
    logic [N-1:0] m_d, m_rise, m_fall, m_h1, m_h2;
    int m_owner, m_cnt, m_last, m_grant;

    task automatic model_reset();
        m_d = '0; m_rise = '0; m_fall = '0; m_h1 = '0; m_h2 = '0;
        m_owner = -1; m_cnt = 0; m_last = N - 1; m_grant = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] b, input logic r);
        logic [N-1:0] s;
        int i, pick;
`ifdef DEBOUNCE_SCHED_SYNC_EN
        s = m_h2; m_h2 = m_h1; m_h1 = b;
`else
        s = b;
`endif
        if (r) begin
            model_reset();
            return;
        end
        m_rise = '0; m_fall = '0;
        if (m_owner < 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (pick < 0 && s[i] != m_d[i]) pick = i;
            end
            if (pick >= 0) begin
                m_owner = pick; m_cnt = 0; m_grant = pick;
            end
        end else if (s[m_owner] == m_d[m_owner]) begin
            m_last = m_owner; m_owner = -1;
        end else if (m_cnt == SC - 1) begin
            m_d[m_owner] = s[m_owner];
            if (s[m_owner]) m_rise[m_owner] = 1'b1;
            else            m_fall[m_owner] = 1'b1;
            m_last = m_owner; m_owner = -1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic check_model();
        logic ok;
        ok = (bus.d === m_d) && (bus.rise === m_rise) && (bus.fall === m_fall) &&
             (bus.busy === (m_owner >= 0)) && (bus.grant === GW'(m_grant));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL model cyc=%0d d=%b/%b rise=%b/%b fall=%b/%b busy=%b/%b grant=%0d/%0d",
                     cyc, bus.d, m_d, bus.rise, m_rise, bus.fall, m_fall,
                     bus.busy, (m_owner >= 0), bus.grant, m_grant);
        end
        checks++;
        if ($countones(bus.rise | bus.fall) > 1) begin
            errors++;
            $display("FAIL pulse_onehot cyc=%0d rise=%b fall=%b required at most one bit", cyc, bus.rise, bus.fall);
        end
    endtask

    // After step returns, bus shows the values of cycle 'cyc' (counted from rst release)
    task automatic step(input logic [N-1:0] b, input logic r);
        @(negedge clk);
        bus.btn = b;
        rst     = r;
        model_edge(b, r);
        @(posedge clk);
        #1;
        check_model();
        if (r) cyc = 0;
        else   cyc++;
    endtask

    task automatic do_reset();
        step('0, 1'b1);
        step('0, 1'b1);
    endtask

    typedef struct {
        logic [N-1:0] btn;
        int           hold;
        logic [N-1:0] exp_d;
    } vec_t;

    vec_t vecs[7];
    int rise_at, rise2_at, fall_at, abort_at, busy_n, pulses, rises, falls, d3_hits, g1, g2;
    logic seen_busy;
    logic [N-1:0] rb;

    initial begin
        bus.btn = '0;
        model_reset();

        vecs[0] = '{4'b0001, 12, 4'b0001};
        vecs[1] = '{4'b0011, 12, 4'b0011};
        vecs[2] = '{4'b0110, 25, 4'b0110};
        vecs[3] = '{4'b0110,  3, 4'b0110};
        vecs[4] = '{4'b1111,  5, 4'b0110};
        vecs[5] = '{4'b0110, 12, 4'b0110};
        vecs[6] = '{4'b0000, 25, 4'b0000};

        do_reset();
        cmp("reset_d", int'(bus.d), 0);
        cmp("reset_busy_grant", int'({bus.busy, bus.grant}), 0);
        for (int v = 0; v < 7; v++) begin
            for (int h = 0; h < vecs[v].hold; h++) step(vecs[v].btn, 1'b0);
            cmp($sformatf("vec%0d_d", v), int'(bus.d), int'(vecs[v].exp_d));
        end

        // Clean press of button 0 at cycle 10
        do_reset();
        rise_at = -1; busy_n = 0;
        while (cyc < 10) step(4'b0000, 1'b0);
        while (cyc < 40) begin
            step(4'b0001, 1'b0);
            if (bus.rise[0] && rise_at < 0) rise_at = cyc;
            if (bus.busy) busy_n++;
        end
        cmp("press_rise0_cycle", rise_at, 19 + LAT);
        cmp("press_busy_cycles", busy_n, 8);
        cmp("press_grant", int'(bus.grant), 0);

        // Bounce at cycle 13: abort seen at 14, re-grant decided there, d rises 9 later
        do_reset();
        rise_at = -1; abort_at = -1; pulses = 0; seen_busy = 1'b0;
        while (cyc < 10) step(4'b0000, 1'b0);
        while (cyc < 40) begin
            step((cyc == 13) ? 4'b0000 : 4'b0001, 1'b0);
            if (bus.busy) seen_busy = 1'b1;
            if (seen_busy && !bus.busy && abort_at < 0) abort_at = cyc;
            if (bus.rise[0] && rise_at < 0) rise_at = cyc;
            pulses += $countones(bus.rise | bus.fall);
        end
        cmp("bounce_abort_cycle", abort_at, 14 + LAT);
        cmp("bounce_rise0_cycle", rise_at, 23 + LAT);
        cmp("bounce_pulse_count", pulses, 1);

        // Buttons 1 and 2 together: strict round-robin from index 0
        do_reset();
        rise_at = -1; rise2_at = -1; g1 = -1; g2 = -1;
        while (cyc < 10) step(4'b0000, 1'b0);
        while (cyc < 45) begin
            step(4'b0110, 1'b0);
            if (bus.rise[1] && rise_at < 0)  begin rise_at  = cyc; g1 = int'(bus.grant); end
            if (bus.rise[2] && rise2_at < 0) begin rise2_at = cyc; g2 = int'(bus.grant); end
        end
        cmp("pair_rise1_cycle", rise_at, 19 + LAT);
        cmp("pair_rise2_cycle", rise2_at, 28 + LAT);
        cmp("pair_grant_first", g1, 1);
        cmp("pair_grant_second", g2, 2);

        // Button 3 chattering every 3 cycles must not starve button 0
        do_reset();
        rise_at = -1; d3_hits = 0;
        while (cyc < 60) begin
            step({((cyc / 3) % 2 == 1), 2'b00, (cyc >= 10)}, 1'b0);
            if (bus.rise[0] && rise_at < 0) rise_at = cyc;
            if (bus.d[3]) d3_hits++;
        end
        cmp("chatter_rise0_in_window", int'(rise_at >= 0 && rise_at <= 10 + LAT + 2 * (SC + 1) + 1), 1);
        cmp("chatter_d3_stays_low", d3_hits, 0);

        // Release: single fall pulse 9 cycles after the change
        do_reset();
        fall_at = -1; rises = 0; falls = 0;
        while (cyc < 15) step(4'b0001, 1'b0);
        cmp("release_pre_d0", int'(bus.d[0]), 1);
        while (cyc < 45) begin
            step(4'b0000, 1'b0);
            if (bus.fall[0] && fall_at < 0) fall_at = cyc;
            rises += int'(bus.rise[0]);
            falls += int'(bus.fall[0]);
        end
        cmp("release_fall0_cycle", fall_at, 24 + LAT);
        cmp("release_fall_count", falls, 1);
        cmp("release_rise_count", rises, 0);

        // Reset in the middle of a COUNT discards it
        do_reset();
        pulses = 0; rise_at = -1;
        while (cyc < 10) step(4'b0000, 1'b0);
        while (cyc < 15) begin
            step(4'b0001, 1'b0);
            pulses += $countones(bus.rise | bus.fall);
        end
        step(4'b0001, 1'b1);
        cmp("midreset_busy", int'(bus.busy), 0);
        cmp("midreset_d", int'(bus.d), 0);
        cmp("midreset_pulses", pulses + $countones(bus.rise | bus.fall), 0);
        while (cyc < 30) begin
            step(4'b0001, 1'b0);
            if (bus.rise[0] && rise_at < 0) rise_at = cyc;
        end
        cmp("midreset_redebounce_cycle", rise_at, 9 + LAT);

        // Random buttons with occasional reset, checked every cycle by the model
        do_reset();
        rb = '0;
        for (int c = 0; c < 3000; c++) begin
            int j;
            if ($urandom_range(7) == 0) begin
                j = $urandom_range(N - 1);
                rb[j] = ~rb[j];
            end
            step(rb, ($urandom_range(399) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
